// File: rtl/main_cmd_seq_pkg.sv
// Shared definitions for the main_core command sequencer: command field sizes,
// FSM state encodings and the position of the isLast flag in a program entry.
package main_cmd_seq_pkg;

    localparam int MAIN_CORE_CMD_WHICH_SIZE = 4;
    localparam int MAIN_CORE_CMD_SIZE       = 12;
    localparam int MAIN_CORE_CMD_W          = MAIN_CORE_CMD_WHICH_SIZE + MAIN_CORE_CMD_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

    // isLast sits directly above the command field: entry = {isLast, cmd}
    function automatic int is_last_pos(input int cmd_w);
        return cmd_w;
    endfunction

    // A requested pass count of zero still runs the program once
    function automatic logic [7:0] iter_load(input logic [7:0] requested);
        if (requested == 8'd0) begin
            return 8'd1;
        end else begin
            return requested;
        end
    endfunction

endpackage

// File: rtl/main_cmd_seq_mem.sv
// Program store for the command sequencer: simple dual-port RAM with a
// registered read port; contents are deliberately not reset.
module cmd_seq_mem #(
    parameter int W     = 17,
    parameter int DEPTH = 32,
    parameter int AW    = 5
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; rdata holds its value while re is low
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/main_cmd_seq.sv
// Sequences programmed main_core commands over a valid/consume handshake,
// looping the program a configurable number of times.
module main_cmd_seq
    import main_cmd_seq_pkg::*;
#(
    parameter int CMD_W = MAIN_CORE_CMD_W,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [CMD_W:0]   prog_data,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [7:0]       iterations,
    input  logic             abort,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_hasAny,
    input  logic             cmd_consume,
    output logic             busy,
    output logic             done
);

    localparam int LAST_BIT = is_last_pos(CMD_W);

    seq_state_e    state_r, state_nxt_s;
    logic [AW-1:0] pc_r, pc_nxt_s;
    logic [AW-1:0] base_r, base_nxt_s;
    logic [7:0]    iter_r, iter_nxt_s;
    logic          has_any_r, busy_r, done_r;
    logic [CMD_W:0] entry_s;
    logic          mem_we_s, mem_re_s, handshake_s, is_last_s;

    assign mem_we_s    = prog_we & (state_r == ST_IDLE);
    assign mem_re_s    = (state_r == ST_FETCH);
    assign handshake_s = has_any_r & cmd_consume;
    assign is_last_s   = entry_s[LAST_BIT];

    cmd_seq_mem #(
        .W     (CMD_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (mem_re_s),
        .raddr (pc_r),
        .rdata (entry_s)
    );

    // Next-state and program-counter / pass-counter update
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        base_nxt_s  = base_r;
        iter_nxt_s  = iter_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt_s    = start_addr;
                    base_nxt_s  = start_addr;
                    iter_nxt_s  = iter_load(iterations);
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake_s) begin
                    // abort racing a handshake: the command still counts as issued
                    if (abort) begin
                        state_nxt_s = ST_FINISH;
                    end else if (!is_last_s) begin
                        pc_nxt_s    = (pc_r == AW'(DEPTH - 1)) ? AW'(0) : pc_r + AW'(1);
                        state_nxt_s = ST_FETCH;
                    end else if (iter_r > 8'd1) begin
                        iter_nxt_s  = iter_r - 8'd1;
                        pc_nxt_s    = base_r;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_FINISH;
                    end
                end else if (abort) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= '0;
            base_r    <= '0;
            iter_r    <= 8'd0;
            has_any_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            base_r    <= base_nxt_s;
            iter_r    <= iter_nxt_s;
            has_any_r <= (state_nxt_s == ST_ISSUE);
            busy_r    <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_ISSUE);
            done_r    <= (state_nxt_s == ST_FINISH);
        end
    end

    assign cmd_hasAny = has_any_r;
    assign cmd        = has_any_r ? entry_s[CMD_W-1:0] : '0;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_main_cmd_seq.sv
// Directed self-checking bench for main_cmd_seq (default CMD_W=16, DEPTH=32).
module tb_main_cmd_seq;

    localparam int CW = 16;
    localparam int AW = 5;

    localparam logic [CW-1:0] CMD_A = 16'hA001;
    localparam logic [CW-1:0] CMD_B = 16'hB002;
    localparam logic [CW-1:0] CMD_C = 16'hC003;
    localparam logic [CW-1:0] CMD_X = 16'h5A5A;
    localparam logic [CW-1:0] CMD_Y = 16'h1234;

    logic          clk = 1'b0;
    logic          rst, prog_we, start, abort, cmd_consume;
    logic [AW-1:0] prog_addr, start_addr;
    logic [CW:0]   prog_data;
    logic [7:0]    iterations;
    logic [CW-1:0] cmd;
    logic          cmd_hasAny, busy, done;

    int checks = 0;
    int errors = 0;

    // capture results of a run
    logic [CW-1:0] hs_cmd[$];
    int            hs_cyc[$];
    int            done_cnt, done_cyc, zero_viol;

    main_cmd_seq dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .start_addr  (start_addr),
        .iterations  (iterations),
        .abort       (abort),
        .cmd         (cmd),
        .cmd_hasAny  (cmd_hasAny),
        .cmd_consume (cmd_consume),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic last, input logic [CW-1:0] c);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = {last, c};
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic load_abc();
        write_entry(5'd0, 1'b0, CMD_A);
        write_entry(5'd1, 1'b0, CMD_B);
        write_entry(5'd2, 1'b1, CMD_C);
    endtask

    // Pulse start for one edge (edge t); cycle numbering below is relative to t
    task automatic launch(input logic [AW-1:0] sa, input logic [7:0] it);
        start_addr = sa;
        iterations = it;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Record handshakes and done pulses, indexed by the edge they are seen at
    task automatic capture(input int budget);
        hs_cmd.delete();
        hs_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        zero_viol = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (!cmd_hasAny && cmd != '0) zero_viol++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cmd_hasAny && cmd_consume) begin
                hs_cmd.push_back(cmd);
                hs_cyc.push_back(cyc);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_hasAny, busy, done} !== 3'b000 || cmd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: hasAny/busy/done=%b cmd=%h, required 000 / 0000",
                     {cmd_hasAny, busy, done}, cmd);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        logic [CW-1:0] exp_cmd [3];
        exp_cmd[0] = CMD_A; exp_cmd[1] = CMD_B; exp_cmd[2] = CMD_C;
        load_abc();
        cmd_consume = 1'b1;
        launch(5'd0, 8'd1);
        checks++;
        if (busy !== 1'b1 || cmd_hasAny !== 1'b0) begin
            errors++;
            $display("FAIL fetch_state: busy=%b hasAny=%b, required 1 0", busy, cmd_hasAny);
        end
        capture(12);
        checks++;
        if (hs_cmd.size() != 3) begin
            errors++;
            $display("FAIL single_count: %0d handshakes, required 3", hs_cmd.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hs_cmd[i] !== exp_cmd[i] || hs_cyc[i] != 2 * i + 2) begin
                    errors++;
                    $display("FAIL single_hs%0d: cmd=%h at t+%0d, required %h at t+%0d",
                             i, hs_cmd[i], hs_cyc[i], exp_cmd[i], 2 * i + 2);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 7) begin
            errors++;
            $display("FAIL single_done: %0d pulses, last at t+%0d, required 1 at t+7", done_cnt, done_cyc);
        end
        checks++;
        if (zero_viol != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: cmd-nonzero-when-invalid=%0d busy=%b, required 0 0", zero_viol, busy);
        end
    endtask

    task automatic test_iterations();
        logic [CW-1:0] exp_cmd [3];
        exp_cmd[0] = CMD_A; exp_cmd[1] = CMD_B; exp_cmd[2] = CMD_C;
        cmd_consume = 1'b1;
        launch(5'd0, 8'd3);
        capture(25);
        checks++;
        if (hs_cmd.size() != 9) begin
            errors++;
            $display("FAIL iter_count: %0d handshakes, required 9", hs_cmd.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (hs_cmd[i] !== exp_cmd[i % 3] || hs_cyc[i] != 2 * i + 2) begin
                    errors++;
                    $display("FAIL iter_hs%0d: cmd=%h at t+%0d, required %h at t+%0d",
                             i, hs_cmd[i], hs_cyc[i], exp_cmd[i % 3], 2 * i + 2);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 19) begin
            errors++;
            $display("FAIL iter_done: %0d pulses, last at t+%0d, required 1 at t+19", done_cnt, done_cyc);
        end
    endtask

    task automatic test_wrap();
        write_entry(5'd31, 1'b0, CMD_X);
        write_entry(5'd0, 1'b1, CMD_Y);
        cmd_consume = 1'b1;
        launch(5'd31, 8'd0);
        capture(10);
        checks++;
        if (hs_cmd.size() != 2) begin
            errors++;
            $display("FAIL wrap_count: %0d handshakes, required 2", hs_cmd.size());
        end else if (hs_cmd[0] !== CMD_X || hs_cmd[1] !== CMD_Y) begin
            errors++;
            $display("FAIL wrap_seq: got %h,%h, required %h,%h", hs_cmd[0], hs_cmd[1], CMD_X, CMD_Y);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL wrap_done: %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_stall_abort();
        load_abc();
        cmd_consume = 1'b0;
        launch(5'd0, 8'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_hasAny !== 1'b1 || cmd !== CMD_A || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: hasAny=%b cmd=%h busy=%b, required 1 %h 1",
                         i, cmd_hasAny, cmd, busy, CMD_A);
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (cmd_hasAny !== 1'b0 || cmd !== 16'h0000 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_issue: hasAny=%b cmd=%h done=%b busy=%b, required 0 0000 1 0",
                     cmd_hasAny, cmd, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_width: done=%b busy=%b, required 0 0", done, busy);
        end
        // abort while fetching ends the run without ever offering a command
        launch(5'd0, 8'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (cmd_hasAny !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_fetch: hasAny=%b done=%b busy=%b, required 0 1 0", cmd_hasAny, done, busy);
        end
        tick();
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_hasAny !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b hasAny=%b, required 0 0 0", busy, done, cmd_hasAny);
        end
    endtask

    task automatic test_reset_mid_run();
        cmd_consume = 1'b1;
        launch(5'd0, 8'd1);
        tick();
        tick();
        tick();
        checks++;
        if (cmd_hasAny !== 1'b1 || cmd !== CMD_B) begin
            errors++;
            $display("FAIL rst_pre_b: hasAny=%b cmd=%h, required 1 %h", cmd_hasAny, cmd, CMD_B);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_hasAny, busy, done} !== 3'b000 || cmd !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_run: hasAny/busy/done=%b cmd=%h, required 000 / 0000",
                     {cmd_hasAny, busy, done}, cmd);
        end
        tick();
        launch(5'd0, 8'd1);
        capture(12);
        checks++;
        if (hs_cmd.size() != 3 || hs_cmd[0] !== CMD_A || hs_cmd[1] !== CMD_B || hs_cmd[2] !== CMD_C) begin
            errors++;
            $display("FAIL rst_restart: %0d handshakes, first=%h, required 3 starting %h",
                     hs_cmd.size(), (hs_cmd.size() > 0) ? hs_cmd[0] : 16'h0000, CMD_A);
        end
    endtask

    task automatic test_busy_ignore();
        cmd_consume = 1'b0;
        launch(5'd0, 8'd1);
        tick();
        prog_we    = 1'b1;
        prog_addr  = 5'd1;
        prog_data  = {1'b1, 16'hDEAD};
        start      = 1'b1;
        start_addr = 5'd1;
        tick();
        tick();
        prog_we     = 1'b0;
        start       = 1'b0;
        cmd_consume = 1'b1;
        capture(16);
        checks++;
        if (hs_cmd.size() != 3 || hs_cmd[0] !== CMD_A || hs_cmd[1] !== CMD_B || hs_cmd[2] !== CMD_C) begin
            errors++;
            $display("FAIL busy_write: %0d handshakes, second=%h, required 3 with second %h",
                     hs_cmd.size(), (hs_cmd.size() > 1) ? hs_cmd[1] : 16'h0000, CMD_B);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: %0d done pulses busy=%b, required 1 0", done_cnt, busy);
        end
    endtask

    initial begin
        rst = 1'b0; prog_we = 1'b0; start = 1'b0; abort = 1'b0; cmd_consume = 1'b0;
        prog_addr = '0; prog_data = '0; start_addr = '0; iterations = 8'd0;
        test_reset();
        test_single_pass();
        test_iterations();
        test_wrap();
        test_stall_abort();
        test_reset_mid_run();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
